// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: datapath width, reset vector and the
// fetch queue entry layout.
package cpu_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; flush wins over push and pop.
// A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: in-order requests to a variable-latency imem,
// returned words buffered with their PCs, redirect flushes and drops in-flight data.
module fetch_queue_unit
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head, push_entry;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CW:0]     credit_used;
    logic            resp_ok, req_fire;
    logic [XLEN-1:0] redirect_target;

    // Outstanding requests (including ones to be dropped) reserve FIFO slots.
    assign credit_used     = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign resp_ok         = imem_resp_valid && (outstanding_q != '0);
    assign redirect_target = redirect_pc & ~XLEN'(3);

    assign imem_req_valid = reset && !halt && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid = !fifo_empty;
    assign inst       = inst_valid ? fifo_head.inst : '0;
    assign inst_pc    = inst_valid ? fifo_head.pc   : '0;
    assign fifo_pop   = inst_valid && inst_ready;
    assign push_entry = '{pc: resp_pc_q, inst: imem_resp_data};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_d        = drop_q;
        fifo_push     = 1'b0;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_ok);
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            drop_d     = outstanding_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (resp_ok) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + XLEN'(4);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        fifo_push |-> (!fifo_full || fifo_pop));
    a_no_spurious_resp: assert property (@(posedge clk) disable iff (!reset)
        imem_resp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit: memory model with in-order variable
// latency, epoch-tagged requests and an expected-FIFO reference.
module tb_fetch_queue_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_queue_unit #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .halt            (halt),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    // Each request carries the redirect epoch it was issued in; a stale epoch means dropped.
    mreq_t       pend_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch_pc;
    int          epoch, last_due, cyc;
    int          n_tests, n_fail;

    int          rdy_pct, mrdy_pct, lat_lo, lat_hi, redir_pct, halt_pct;
    logic        halt_force, redir_once;
    logic [31:0] redir_tgt;

    logic [31:0] req_log[$];
    int          req_cyc[$];
    logic [31:0] dl_pc[$];
    logic [31:0] dl_data[$];
    int          dl_cyc[$];
    logic        s_req_valid, s_inst_valid;
    logic [31:0] s_inst_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        req_cyc.delete();
        dl_pc.delete();
        dl_data.delete();
        dl_cyc.delete();
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        halt            = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b0;
        pend_q.delete();
        exp_q.delete();
        exp_fetch_pc = 32'h0;
        epoch        = 0;
        last_due     = 0;
        clear_logs();
        #1;
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // One cycle: drive at posedge+1, check and advance the model at negedge.
    task automatic step();
        mreq_t       r;
        logic [63:0] pe;
        logic        keep, exp_valid, exp_rv;
        int          due;

        halt = halt_force || ($urandom_range(99) < halt_pct);
        if (redir_once) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redir_once     = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(99) < redir_pct);
            redirect_pc    = $urandom;
        end
        inst_ready     = ($urandom_range(99) < rdy_pct);
        imem_req_ready = ($urandom_range(99) < mrdy_pct);
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_q[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end

        @(negedge clk);
        exp_valid = (exp_q.size() != 0);
        exp_rv    = !halt && !redirect_valid && ((pend_q.size() + exp_q.size()) < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) check("req_addr", imem_req_addr, exp_fetch_pc);
        check("inst_valid", inst_valid, exp_valid);
        if (exp_valid) begin
            check("inst_pc", inst_pc, exp_q[0][63:32]);
            check("inst", inst, exp_q[0][31:0]);
        end
        s_req_valid  = imem_req_valid;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;

        keep = 1'b0;
        r    = '{addr: 32'h0, due: 0, epoch: 0};
        if (imem_resp_valid) begin
            r    = pend_q.pop_front();
            keep = (r.epoch == epoch) && !redirect_valid;
        end
        if (redirect_valid) begin
            exp_q.delete();
            epoch++;
            exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (exp_valid && inst_ready) begin
                pe = exp_q.pop_front();
                dl_pc.push_back(pe[63:32]);
                dl_data.push_back(pe[31:0]);
                dl_cyc.push_back(cyc);
            end
            if (keep) exp_q.push_back({r.addr, mem_word(r.addr)});
        end
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_q.push_back('{addr: imem_req_addr, due: due, epoch: epoch});
            req_log.push_back(imem_req_addr);
            req_cyc.push_back(cyc);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int rdy, input int mrdy, input int llo, input int lhi,
                            input int rp, input int hp);
        rdy_pct   = rdy;
        mrdy_pct  = mrdy;
        lat_lo    = llo;
        lat_hi    = lhi;
        redir_pct = rp;
        halt_pct  = hp;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        halt_force = 1'b0;
        redir_once = 1'b0;
        redir_tgt  = '0;
        set_mode(100, 100, 1, 1, 0, 0);
        do_reset();

        // Streaming at latency 1
        repeat (8) step();
        check("t1_req0", req_log[0], 32'h0);
        check("t1_req1", req_log[1], 32'h4);
        check("t1_req2", req_log[2], 32'h8);
        check("t1_first_pc", dl_pc[0], 32'h0);
        check("t1_latency", dl_cyc[0] - req_cyc[0], 32'd2);
        check("t1_rate", dl_cyc[1] - dl_cyc[0], 32'd1);
        check("t1_second_pc", dl_pc[1], 32'h4);

        // Decode stalled: credit caps requests at DEPTH
        do_reset();
        set_mode(0, 100, 1, 1, 0, 0);
        repeat (10) step();
        check("t2_nreq", req_log.size(), 32'd4);
        check("t2_last_req", req_log[3], 32'hC);
        check("t2_req_blocked", s_req_valid, 1'b0);
        check("t2_head_valid", s_inst_valid, 1'b1);
        check("t2_head_pc", s_inst_pc, 32'h0);
        set_mode(100, 100, 1, 1, 0, 0);
        repeat (10) step();
        check("t2_resume", req_log[4], 32'h10);
        check("t2_drain0", dl_pc[0], 32'h0);
        check("t2_drain3", dl_pc[3], 32'hC);

        // Redirect with three requests in flight
        do_reset();
        set_mode(100, 100, 4, 4, 0, 0);
        repeat (3) step();
        check("t3_inflight", pend_q.size(), 32'd3);
        clear_logs();
        redir_once = 1'b1;
        redir_tgt  = 32'h100;
        repeat (16) step();
        check("t3_req0", req_log[0], 32'h100);
        check("t3_first_pc", dl_pc[0], 32'h100);
        check("t3_first_data", dl_data[0], mem_word(32'h100));

        // Redirect colliding with a response and a pop; low bits ignored
        set_mode(100, 100, 1, 1, 0, 0);
        repeat (6) step();
        clear_logs();
        redir_once = 1'b1;
        redir_tgt  = 32'h203;
        step();
        step();
        check("t4_empty_after", s_inst_valid, 1'b0);
        repeat (6) step();
        check("t4_req0", req_log[0], 32'h200);
        check("t4_first_pc", dl_pc[0], 32'h200);

        // Fetch address wraps past the top of memory
        clear_logs();
        redir_once = 1'b1;
        redir_tgt  = 32'hFFFF_FFF8;
        repeat (8) step();
        check("t5_req0", req_log[0], 32'hFFFF_FFF8);
        check("t5_req1", req_log[1], 32'hFFFF_FFFC);
        check("t5_wrap", req_log[2], 32'h0);
        check("t5_wrap_pc", dl_pc[2], 32'h0);

        // Halt stops issue but lets in-flight work drain
        set_mode(100, 100, 3, 3, 0, 0);
        repeat (6) step();
        clear_logs();
        halt_force = 1'b1;
        repeat (8) step();
        check("t6_no_req", req_log.size(), 32'd0);
        check("t6_req_low", s_req_valid, 1'b0);
        check("t6_drained", pend_q.size() + exp_q.size(), 32'd0);
        halt_force = 1'b0;
        step();
        check("t6_resume", req_log.size(), 32'd1);

        // Randomized traffic, including a reset in the middle
        set_mode(70, 80, 1, 5, 3, 5);
        repeat (1500) step();
        set_mode(20, 90, 1, 4, 2, 3);
        repeat (500) step();
        do_reset();
        set_mode(80, 70, 1, 6, 4, 5);
        repeat (1500) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction-fetch front end between the PC/instruction memory and the decode/control path of the RV32I core.
- Issues in-order word fetches to a variable-latency instruction memory and buffers returned instructions with their PCs in a small FIFO.
- Hands instructions to decode over a valid/ready handshake.
- Accepts a redirect (branch/jal/jalr target) that flushes the FIFO and discards all in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; also caps in-flight requests (power of two, >=2)
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
halt  in  1  stop issuing new requests (ecall halt); in-flight requests still complete
redirect_valid  in  1  one-cycle redirect strobe
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word address of request
imem_resp_valid  in  1  one-cycle response strobe; in request order; always accepted
imem_resp_data  in  XLEN  fetched instruction
inst_valid  out  1  FIFO head valid
inst_ready  in  1  decode consumes head
inst  out  XLEN  head instruction
inst_pc  out  XLEN  PC of head instruction

Behaviour:
- Reset (reset==0, asynchronous):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO count=0; outstanding=0; drop=0.
  - inst_valid=0, inst=0, inst_pc=0, imem_req_valid=0.
- Request issue:
  - imem_req_valid = !halt && !redirect_valid && (outstanding + count) < DEPTH.
  - imem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
  - Minimum latency: request at cycle N, response at N+1, inst_valid at N+2.
- Response:
  - Every imem_resp_valid decrements outstanding.
  - If drop>0: data discarded, drop -= 1.
  - Else push {resp_pc, imem_resp_data} into the FIFO; resp_pc += 4.
- Credit rule: outstanding includes to-be-dropped requests, so a push never hits a full FIFO. Overflow is impossible by construction; assert it.
- Output: inst_valid = (count != 0); inst/inst_pc = head entry. Pop on inst_valid && inst_ready.
- Simultaneous push and pop: count unchanged; FIFO with count==DEPTH-1 plus push and pop stays correct.
- Redirect cycle (highest priority):
  - FIFO flushed to count=0; any pop this cycle is void.
  - fetch_pc = resp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - No request issued this cycle.
  - A response arriving this cycle is discarded.
  - outstanding_next = outstanding - resp; drop_next = outstanding_next.
  - Next cycle inst_valid=0; requests resume from the target.
- Back-to-back redirects: the last one wins; drop is recomputed each time.
- halt: holds fetch_pc; FIFO keeps draining to decode; a redirect while halted still updates PCs and flushes.
- imem_resp_valid with outstanding==0: protocol violation. Ignore it (no state change) and assert.
- Reset mid-operation: all state returns to reset values immediately. Stale memory responses after reset release are the memory's responsibility; the memory must also be reset.
- Counter widths: count and outstanding are clog2(DEPTH)+1 bits; drop is the same width.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN, INST_NOP (32'h0000_0013), RESET_PC default.
  - fetch_entry_t struct {pc, inst}.
- One natural sub-module: sync_fifo (parameterised DEPTH and WIDTH, with flush, push, pop, count, head outputs). It is reusable later for a store buffer.
- Counters, drop logic and PC registers stay in fetch_queue_unit.

Test Plan:
- Reset release, memory latency 1, inst_ready=1 -> requests at 0x0, 0x4, 0x8…; inst_pc 0x0 appears 2 cycles after the first request; one instruction per cycle thereafter.
- inst_ready=0 held, latency 1 -> exactly DEPTH=4 requests issued (0x0–0xC), then imem_req_valid=0; the FIFO holds 4 entries; releasing ready drains them in order and fetching resumes at 0x10.
- Latency 3 with 3 requests in flight, redirect to 0x100 -> the next 3 responses are dropped; the first inst_valid shows inst_pc=0x100 with the data returned for 0x100.
- Redirect on the same cycle as a response and a pop -> the response is dropped, the FIFO is empty the next cycle, and the next request address is the target.
- halt=1 with 2 in flight -> no new requests; both instructions are delivered; imem_req_valid stays 0 until halt=0.
- redirect_pc=0x203 -> the fetch address is 0x200; fetch_pc at 0xFFFF_FFFC advances to 0x0000_0000.
